oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
OAM DMA controller and bus arbiter for the DMG core. It decodes CPU writes to $FF46 and sequences a 160-byte copy from {page,$00..$9F} into OAM ($FE00-$FE9F). It owns the shared cart/iram/vram source bus while a transfer is running and flags CPU accesses outside $FF00-$FFFF as blocked. It sits between the CPU decode, the source memories (cart/iram/vram muxing stays in the top level) and the OAM write port of the video block.

Parameters:
XFER_LEN, 160, bytes per transfer (1..256)
CE_DIV, 4, clocks per transferred byte (one M-cycle); must be >= 4
START_DELAY, 1, M-cycles between trigger and first source read

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous reset, active low
cpu_addr  input  16  CPU address
cpu_wr_n  input  1  CPU write strobe, active low
cpu_rd_n  input  1  CPU read strobe, active low
cpu_do  input  8  CPU write data
reg_do  output  8  $FF46 readback: last written page
dma_active  output  1  high from trigger until last byte completes
src_addr  output  16  source address, valid while src_rd
src_rd  output  1  source read request
src_data  input  8  source data, 1-clock latency after src_addr/src_rd
oam_addr  output  8  OAM byte index
oam_wr  output  1  single-clock OAM write strobe
oam_data  output  8  OAM write data
cpu_blocked  output  1  CPU access that must be ignored/return blocked_do
blocked_do  output  8  data the top level returns for blocked CPU reads

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (reset_n). When reset_n is low at a clk edge: state IDLE, reg_do=$00, index=0, phase=0. All strobes and dma_active are 0. oam_addr, oam_data and src_addr are 0.
- Trigger: a write is a clock where cpu_addr==$FF46 and cpu_wr_n=0, and the previous clock did not have cpu_wr_n=0 at $FF46. This edge detection is registered, so a multi-clock strobe yields exactly one trigger. On a trigger: reg_do<=cpu_do, page latched, index<=0, phase<=0, state<=START.
- Source page mapping: page >= $E0 maps to page-$20 (echo RAM onto $C0-$DF). Otherwise the page is used as-is. src_addr = {mapped_page, index[7:0]}.
- States:
  - IDLE -> START on trigger.
  - START counts START_DELAY*CE_DIV clocks, then goes to XFER.
  - XFER -> IDLE after phase CE_DIV-1 of byte XFER_LEN-1.
- XFER phases per byte:
  - phase 0: src_rd=1.
  - phase 1: src_rd=1, src_data is sampled into the data latch.
  - phase 2: oam_wr=1, oam_addr=index, oam_data=latch.
  - phases 3..CE_DIV-1: idle. At phase CE_DIV-1, index increments and phase wraps to 0.
- dma_active is registered: it goes high the clock after the trigger and low the clock after the final phase.
- Latency with defaults: the first src_rd is 1+4 clocks after the trigger clock. The last oam_wr is at trigger+5+159*4+2. dma_active stays high for 644 clocks.
- cpu_blocked (combinational) = state==XFER && cpu_addr<$FF00 && (cpu_rd_n==0 || cpu_wr_n==0). There is no blocking during START.
- Retrigger while in START or XFER: the transfer restarts with the new page, index 0, state START. A byte whose phase 2 has not yet occurred is never written. dma_active stays high continuously.
- A trigger in the same clock as the final phase: the restart wins, and dma_active does not drop.
- Reset mid-transfer: the transfer aborts the next clock edge with no further oam_wr.
- The index never wraps past XFER_LEN-1.

Optional Feature:
OAM_DMA_BUS_CONFLICT_EN.
- Defined: blocked_do = the byte currently held in the data latch, which models the DMG bus conflict.
- Undefined: blocked_do = $FF constant, and the latch is not routed out.

Test Plan:
- Write $C1 to $FF46 (single-clock strobe), source returns low address byte. Expect 160 oam_wr pulses with oam_addr 0..$9F and oam_data = addr[7:0]. src_addr runs $C100..$C19F. dma_active is high for 644 clocks. reg_do=$C1.
- Write $E3. Expect src_addr $C300..$C39F (echo mapping).
- Start with $80. At byte 50, before phase 2, write $90. Expect no write for byte 50 of the old transfer. A new START is followed by 160 writes from $9000. dma_active never drops.
- During XFER: CPU read at $C000 gives cpu_blocked=1. Reads at $FF80 and $FF44 give cpu_blocked=0. During START, a read at $C000 gives cpu_blocked=0. blocked_do is $FF with the macro off, and equals the latched byte with it on.
- Hold cpu_wr_n low at $FF46 for 3 clocks. Expect exactly one trigger.
- Pull reset_n low for one clock mid-XFER. The next edge gives IDLE, reg_do=$00, dma_active=0, and no further oam_wr.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: $FF46 write trigger, 160-byte page copy into OAM, CPU bus arbitration.
// Optional macro OAM_DMA_BUS_CONFLICT_EN routes the DMA data latch to blocked_do.
module oam_dma_ctrl #(
  parameter int XFER_LEN    = 160,
  parameter int CE_DIV      = 4,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr_n,
  input  logic        cpu_rd_n,
  input  logic [7:0]  cpu_do,
  output logic [7:0]  reg_do,
  output logic        dma_active,
  output logic [15:0] src_addr,
  output logic        src_rd,
  input  logic [7:0]  src_data,
  output logic [7:0]  oam_addr,
  output logic        oam_wr,
  output logic [7:0]  oam_data,
  output logic        cpu_blocked,
  output logic [7:0]  blocked_do
);

  localparam int PW         = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int START_CLKS = START_DELAY * CE_DIV;

  localparam logic [PW-1:0] PHASE_LAST = PW'(CE_DIV - 1);
  localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
  localparam logic [PW-1:0] PHASE_TWO  = PW'(2);
  localparam logic [7:0]    INDEX_LAST = 8'(XFER_LEN - 1);
  localparam logic [15:0]   START_LAST = 16'((START_CLKS > 0) ? START_CLKS - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER
  } state_t;

  state_t        state, state_n;
  logic [15:0]   cnt, cnt_n;
  logic [PW-1:0] phase, phase_n;
  logic [7:0]    index, index_n;
  logic [7:0]    page, page_n;
  logic [7:0]    reg_n;
  logic          active_n;
  logic [7:0]    latch, latch_n;
  logic          wr_seen;
  logic          hit;
  logic          trigger;
  logic [7:0]    mapped_page;

  // wr_seen remembers last clock's $FF46 write so a long strobe triggers once
  assign hit     = (cpu_addr == 16'hFF46) && !cpu_wr_n;
  assign trigger = hit && !wr_seen;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      phase      <= '0;
      index      <= '0;
      page       <= '0;
      reg_do     <= '0;
      dma_active <= 1'b0;
      latch      <= '0;
      wr_seen    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      phase      <= phase_n;
      index      <= index_n;
      page       <= page_n;
      reg_do     <= reg_n;
      dma_active <= active_n;
      latch      <= latch_n;
      wr_seen    <= hit;
    end
  end

  // A trigger overrides everything else, including the final-phase return to IDLE
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    phase_n  = phase;
    index_n  = index;
    page_n   = page;
    reg_n    = reg_do;
    active_n = dma_active;
    latch_n  = latch;

    case (state)
      IDLE: begin
      end
      START: begin
        if (cnt == START_LAST) begin
          state_n = XFER;
          cnt_n   = '0;
          phase_n = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      XFER: begin
        if (phase == PHASE_ONE) latch_n = src_data;
        if (phase == PHASE_LAST) begin
          phase_n = '0;
          if (index == INDEX_LAST) begin
            state_n  = IDLE;
            active_n = 1'b0;
          end else begin
            index_n = index + 8'd1;
          end
        end else begin
          phase_n = phase + PW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (trigger) begin
      reg_n    = cpu_do;
      page_n   = cpu_do;
      index_n  = '0;
      phase_n  = '0;
      cnt_n    = '0;
      state_n  = START;
      active_n = 1'b1;
    end
  end

  // Echo RAM pages $E0-$FF alias onto work RAM $C0-$DF
  assign mapped_page = (page >= 8'hE0) ? (page - 8'h20) : page;

  assign src_rd      = (state == XFER) && (phase < PHASE_TWO);
  assign src_addr    = src_rd ? {mapped_page, index} : 16'h0000;
  assign oam_wr      = (state == XFER) && (phase == PHASE_TWO);
  assign oam_addr    = oam_wr ? index : 8'h00;
  assign oam_data    = oam_wr ? latch : 8'h00;
  assign cpu_blocked = (state == XFER) && (cpu_addr < 16'hFF00) && (!cpu_rd_n || !cpu_wr_n);

`ifdef OAM_DMA_BUS_CONFLICT_EN
  assign blocked_do = latch;
`else
  assign blocked_do = 8'hFF;
`endif

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: random CPU traffic against a cycle-indexed transfer model.
// Honours OAM_DMA_BUS_CONFLICT_EN for the blocked_do expectation.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic        cpu_wr_n;
  logic        cpu_rd_n;
  logic [7:0]  cpu_do;
  logic [7:0]  reg_do;
  logic        dma_active;
  logic [15:0] src_addr;
  logic        src_rd;
  logic [7:0]  src_data;
  logic [7:0]  oam_addr;
  logic        oam_wr;
  logic [7:0]  oam_data;
  logic        cpu_blocked;
  logic [7:0]  blocked_do;

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;
  bit mon_en     = 1'b0;
  int wr_count   = 0;
  int act_count  = 0;

  // Transfer model: start cycle of the running transfer (-1 when idle) plus latched page/regs
  int         xs     = -1;
  logic [7:0] mpage  = 8'h00;
  logic [7:0] mreg   = 8'h00;
  logic [7:0] mlatch = 8'h00;
  bit         mprev  = 1'b0;

  oam_dma_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_wr_n(cpu_wr_n),
    .cpu_rd_n(cpu_rd_n), .cpu_do(cpu_do), .reg_do(reg_do), .dma_active(dma_active),
    .src_addr(src_addr), .src_rd(src_rd), .src_data(src_data), .oam_addr(oam_addr),
    .oam_wr(oam_wr), .oam_data(oam_data), .cpu_blocked(cpu_blocked), .blocked_do(blocked_do)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] + a[15:8];
  endfunction

  function automatic logic [7:0] map_page(input logic [7:0] p);
    return (p >= 8'hE0) ? p - 8'h20 : p;
  endfunction

  // Source memory: registered read, garbage when not addressed
  always @(posedge clk) src_data <= src_rd ? mem_byte(src_addr) : 8'($urandom);

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      int k, ph, bt;
      bit in_xfer, exp_act, exp_wr, exp_rd, exp_blk, hit, trig;
      logic [15:0] a;
      k       = (xs >= 0) ? cyc - xs - 5 : -1;
      in_xfer = (xs >= 0) && (k >= 0);
      ph      = in_xfer ? k % 4 : 0;
      bt      = in_xfer ? k / 4 : 0;
      a       = {map_page(mpage), 8'(bt)};
      exp_act = (xs >= 0) && (cyc > xs);
      exp_wr  = in_xfer && (ph == 2);
      exp_rd  = in_xfer && (ph < 2);
      exp_blk = in_xfer && (cpu_addr < 16'hFF00) && (!cpu_rd_n || !cpu_wr_n);

      checkOutput("dma_active", 16'(dma_active), 16'(exp_act));
      checkOutput("reg_do", 16'(reg_do), 16'(mreg));
      checkOutput("oam_wr", 16'(oam_wr), 16'(exp_wr));
      checkOutput("src_rd", 16'(src_rd), 16'(exp_rd));
      checkOutput("cpu_blocked", 16'(cpu_blocked), 16'(exp_blk));
      if (exp_wr) begin
        checkOutput("oam_addr", 16'(oam_addr), 16'(bt));
        checkOutput("oam_data", 16'(oam_data), 16'(mem_byte(a)));
      end
      if (exp_rd) checkOutput("src_addr", src_addr, a);
`ifdef OAM_DMA_BUS_CONFLICT_EN
      checkOutput("blocked_do", 16'(blocked_do), 16'(mlatch));
`else
      checkOutput("blocked_do", 16'(blocked_do), 16'h00FF);
`endif
      if (oam_wr === 1'b1) wr_count++;
      if (dma_active === 1'b1) act_count++;

      hit  = (cpu_addr == 16'hFF46) && !cpu_wr_n;
      trig = hit && !mprev;
      if (!reset_n) begin
        xs = -1; mreg = 8'h00; mlatch = 8'h00; mprev = 1'b0;
      end else begin
        if (in_xfer && ph == 1) mlatch = mem_byte(a);
        if (trig) begin
          xs = cyc; mpage = cpu_do; mreg = cpu_do;
        end else if (xs >= 0 && cyc == xs + 644) begin
          xs = -1;
        end
        mprev = hit;
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] a, input logic wr_n, input logic rd_n,
                               input logic [7:0] d);
    cpu_addr = a; cpu_wr_n = wr_n; cpu_rd_n = rd_n; cpu_do = d;
    @(posedge clk);
    #1;
  endtask

  task automatic run_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a;
      case ($urandom_range(0, 3))
        0: a = 16'hC000 | 16'($urandom_range(0, 255));
        1: a = 16'hFF80;
        2: a = 16'hFF44;
        default: a = 16'($urandom_range(0, 16'hFEFF));
      endcase
      applyStimulus(a, 1'($urandom), 1'($urandom), 8'($urandom));
    end
  endtask

  task automatic clear_counts();
    wr_count = 0; act_count = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_addr = 16'h0000; cpu_wr_n = 1'b1; cpu_rd_n = 1'b1; cpu_do = 8'h00;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    applyStimulus(16'h0000, 1'b1, 1'b1, 8'h00);
    reset_n = 1'b1;
    run_traffic(4);

    clear_counts();
    applyStimulus(16'hFF46, 1'b0, 1'b1, 8'hC1);
    applyStimulus(16'hC000, 1'b1, 1'b0, 8'h00);
    run_traffic(660);
    checkOutput("c1_writes", 16'(wr_count), 16'd160);
    checkOutput("c1_active", 16'(act_count), 16'd644);
    checkOutput("c1_reg", 16'(reg_do), 16'h00C1);

    clear_counts();
    applyStimulus(16'hFF46, 1'b0, 1'b1, 8'hE3);
    run_traffic(660);
    checkOutput("e3_writes", 16'(wr_count), 16'd160);

    clear_counts();
    applyStimulus(16'hFF46, 1'b0, 1'b1, 8'h80);
    run_traffic(205);
    applyStimulus(16'hFF46, 1'b0, 1'b1, 8'h90);
    run_traffic(660);
    checkOutput("retrig_writes", 16'(wr_count), 16'd210);
    checkOutput("retrig_active", 16'(act_count), 16'd850);

    clear_counts();
    for (int i = 0; i < 3; i++) applyStimulus(16'hFF46, 1'b0, 1'b1, 8'hA5);
    run_traffic(660);
    checkOutput("hold_writes", 16'(wr_count), 16'd160);
    checkOutput("hold_active", 16'(act_count), 16'd644);

    clear_counts();
    applyStimulus(16'hFF46, 1'b0, 1'b1, 8'h42);
    run_traffic(643);
    applyStimulus(16'hFF46, 1'b0, 1'b1, 8'h17);
    run_traffic(660);
    checkOutput("final_retrig_writes", 16'(wr_count), 16'd320);
    checkOutput("final_retrig_active", 16'(act_count), 16'd1288);

    clear_counts();
    applyStimulus(16'hFF46, 1'b0, 1'b1, 8'h55);
    run_traffic(300);
    reset_n = 1'b0;
    applyStimulus(16'hC000, 1'b1, 1'b0, 8'h00);
    reset_n = 1'b1;
    run_traffic(400);
    checkOutput("reset_writes", 16'(wr_count), 16'd74);
    checkOutput("reset_reg", 16'(reg_do), 16'h0000);

    for (int r = 0; r < 3; r++) begin
      logic [7:0] p;
      p = 8'($urandom);
      clear_counts();
      applyStimulus(16'hFF46, 1'b0, 1'b1, p);
      run_traffic(660);
      checkOutput("rand_writes", 16'(wr_count), 16'd160);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
